test_controller: RTL
====================

TEST_CONTROLLER -- requirements
Module: test_controller

Interface
REQ-001 SHALL have parameter XLEN, 32, data width of the snooped store bus and of result.
REQ-002 SHALL have parameter ADDR_WIDTH, 32, width of the snooped store address.
REQ-003 SHALL have parameter RESET_CYCLES, 4, cycles core_resetn is held low after start (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 50000, RUN-cycle watchdog limit (>=2).
REQ-005 SHALL have parameter TOHOST_ADDR, 32'h0000_1000, test-completion mailbox address.
REQ-006 SHALL have parameter CONSOLE_ADDR, 32'h0000_1004, character output address.
REQ-007 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, one clock, reset is synchronous and active-low.
REQ-008 SHALL have ports: start  in  1  begin test pulse; trap  in  1  core trap level.
REQ-009 SHALL have ports: d_wen  in  1  store strobe; d_addr  in  ADDR_WIDTH  store address; d_data  in  XLEN  store data.
REQ-010 SHALL have ports: core_resetn  out  1  core reset (active-low); done  out  1  test finished; pass  out  1  test passed.
REQ-011 SHALL have ports: reason  out  2  0=tohost pass,1=tohost fail,2=trap,3=timeout; result  out  XLEN  last tohost word.
REQ-012 SHALL have ports: cycles  out  $clog2(TIMEOUT_CYCLES+1)  RUN-cycle count; char_valid  out  1  console pulse; char_data  out  8  console byte.

Function
REQ-013 SHALL implement states IDLE, HOLD, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 -> HOLD next edge; hold counter loaded to 0; done, pass, reason, result, cycles cleared on that edge.
REQ-015 HOLD: counter increments per cycle; after exactly RESET_CYCLES cycles in HOLD -> RUN.
REQ-016 core_resetn SHALL be 1 only in RUN (registered, high from the first RUN cycle); 0 in IDLE, HOLD, DONE.
REQ-017 RUN: cycles increments on every edge taken in RUN, including the terminating edge, starting from 0 at RUN entry.
REQ-018 RUN: d_wen=1 and d_addr==TOHOST_ADDR and d_data[0]=1 -> DONE; result<=d_data; pass=(d_data==1); reason=0 if pass else 1.
REQ-019 RUN: tohost store with d_data[0]=0 SHALL be ignored (no state change, result unchanged).
REQ-020 RUN: trap=1 -> DONE, pass=0, reason=2.
REQ-021 RUN: cycles==TIMEOUT_CYCLES-1 with no tohost/trap event -> DONE, cycles=TIMEOUT_CYCLES, pass=0, reason=3.
REQ-022 Simultaneous events priority: valid tohost write > trap > timeout.
REQ-023 RUN: d_wen=1 and d_addr==CONSOLE_ADDR -> char_data<=d_data[7:0], char_valid=1 for exactly one cycle; other states never pulse char_valid.
REQ-024 Console and tohost stores to any other address SHALL be ignored; d_wen=0 ignores address/data.
REQ-025 done=1 exactly while in DONE; done, pass, reason, result, cycles stable in DONE.
REQ-026 DONE: start=1 -> HOLD (restart, clears status as REQ-014); start in HOLD or RUN ignored.
REQ-027 cycles SHALL never exceed TIMEOUT_CYCLES (no wrap).

Reset
REQ-028 resetn=0 at a clock edge -> IDLE; core_resetn=0, done=0, pass=0, reason=0, result=0, cycles=0, char_valid=0, char_data=0.
REQ-029 Reset mid-HOLD/RUN/DONE SHALL abort immediately with REQ-028 values; resetn priority over start and all events.

Verification (RESET_CYCLES=4, TIMEOUT_CYCLES=100, TOHOST_ADDR=0x1000, CONSOLE_ADDR=0x1004)
REQ-030 start pulse at edge t -> core_resetn=0 edges t+1..t+4, 1 from t+5; cycles=0 at t+5.
REQ-031 In RUN, store 0x1000 <- 1 on RUN cycle 10 -> done=1, pass=1, reason=0, result=1, cycles=10, core_resetn=0.
REQ-032 Store 0x1000 <- 7 -> pass=0, reason=1, result=7; separately store 0x1000 <- 6 -> ignored, RUN continues.
REQ-033 No events -> done after 100 RUN cycles, reason=3, cycles=100; trap and tohost<-1 same cycle -> reason=0, pass=1.
REQ-034 Stores 0x1004 <- 0x4F, 0x4B, 0x0A -> three single-cycle char_valid pulses, char_data "O","K","\n".
REQ-035 resetn=0 on RUN cycle 50 -> IDLE, all outputs per REQ-028; new start runs normal sequence.

Source files
------------

// File: rtl/test_controller.sv
// Test harness sequencer: holds the core in reset, then watches its stores for
// a tohost verdict, a console byte, a trap or a watchdog timeout.
module test_controller #(
  parameter int          XLEN           = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          RESET_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1004
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  start,
  input  logic                                  trap,
  input  logic                                  d_wen,
  input  logic [ADDR_WIDTH-1:0]                 d_addr,
  input  logic [XLEN-1:0]                       d_data,
  output logic                                  core_resetn,
  output logic                                  done,
  output logic                                  pass,
  output logic [1:0]                            reason,
  output logic [XLEN-1:0]                       result,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   cycles,
  output logic                                  char_valid,
  output logic [7:0]                            char_data,
  output logic [1:0]                            dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          tohost_hit;
  logic          console_hit;

  // Only odd tohost words end the test; even ones are progress markers.
  assign tohost_hit  = d_wen && (d_addr == ADDR_WIDTH'(TOHOST_ADDR)) && d_data[0];
  assign console_hit = d_wen && (d_addr == ADDR_WIDTH'(CONSOLE_ADDR));
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      core_resetn <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      reason      <= 2'd0;
      result      <= '0;
      cycles      <= '0;
      char_valid  <= 1'b0;
      char_data   <= 8'd0;
    end else begin
      char_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= HOLD;
            hold_cnt <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            reason   <= 2'd0;
            result   <= '0;
            cycles   <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
            state       <= RUN;
            core_resetn <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (console_hit) begin
            char_valid <= 1'b1;
            char_data  <= d_data[7:0];
          end
          // The terminating edge counts too, so a timeout reports exactly TIMEOUT_CYCLES.
          cycles <= cycles + 1'b1;
          if (tohost_hit) begin
            state       <= DONE;
            done        <= 1'b1;
            core_resetn <= 1'b0;
            result      <= d_data;
            pass        <= (d_data == XLEN'(1));
            reason      <= (d_data == XLEN'(1)) ? 2'd0 : 2'd1;
          end else if (trap) begin
            state       <= DONE;
            done        <= 1'b1;
            core_resetn <= 1'b0;
            pass        <= 1'b0;
            reason      <= 2'd2;
          end else if (cycles == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            core_resetn <= 1'b0;
            pass        <= 1'b0;
            reason      <= 2'd3;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
